// File: rtl/sensor_packet_framer.sv
// sensor_packet_framer
//   Snapshots the sensor classes, fault bitmap and actuator bitmap. It then sends
//   one 8-byte link packet, a byte at a time, to a UART transmitter using a
//   valid/ready handshake.
//   Packet layout: HEADER, temp, humidity, light, soil, fault_flags,
//   actuator_status, checksum. The checksum is the 8-bit sum of bytes 1..6.
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     send_req          packet request (level or pulse)
//     sensor_*          2-bit sensor classes (zero-extended into their bytes)
//     fault_flags       fault bitmap; a change from the last sent value triggers a packet
//     actuator_status   actuator bitmap
//     tx_data/tx_valid  byte and its valid flag towards uart_tx
//     tx_ready          uart_tx is accepting
//     busy              packet in progress
//     packet_done       one-cycle pulse after the checksum byte has been accepted
//     pkt_count         completed packets, wraps modulo 256
module sensor_packet_framer #(
  parameter logic [7:0]  HEADER        = 8'hAA,
  parameter int unsigned PERIOD_CYCLES = 5000000,
  parameter int          TIMER_W       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send_req,
  input  logic [1:0] sensor_temp,
  input  logic [1:0] sensor_humidity,
  input  logic [1:0] sensor_light,
  input  logic [1:0] sensor_soil,
  input  logic [7:0] fault_flags,
  input  logic [7:0] actuator_status,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       packet_done,
  output logic [7:0] pkt_count
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t     state_reg, state_next;
  logic [2:0] idx_reg;
  logic       last_byte_reg;   // the checksum byte has been transferred; GAP closes the packet
  logic       pending_reg;
  logic [7:0] last_fault_reg;
  logic [7:0] pkt_count_reg;
  logic [7:0] pkt_reg [0:7];   // packet image, captured in LOAD

  logic       expiry;
  logic       fault_trig;
  logic       trigger;
  logic [1:0] field [0:3];
  logic [7:0] snap  [0:7];

  // ---------------------------------------------------------------------------
  // Periodic timer. It runs in every state. With PERIOD_CYCLES = 0 it is absent.
  // ---------------------------------------------------------------------------
  generate
    if (PERIOD_CYCLES == 0) begin : g_no_timer
      assign expiry = 1'b0;
    end else begin : g_timer
      logic [TIMER_W-1:0] timer_reg;
      localparam logic [TIMER_W-1:0] LAST = TIMER_W'(PERIOD_CYCLES - 1);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          timer_reg <= '0;
        else if (timer_reg == LAST)
          timer_reg <= '0;
        else
          timer_reg <= timer_reg + 1'b1;
      end

      assign expiry = (timer_reg == LAST);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Snapshot image: header, four zero-extended classes, two bitmaps, checksum.
  // ---------------------------------------------------------------------------
  assign field[0] = sensor_temp;
  assign field[1] = sensor_humidity;
  assign field[2] = sensor_light;
  assign field[3] = sensor_soil;

  assign snap[0] = HEADER;
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_field
      assign snap[gi+1] = {6'b0, field[gi]};
    end
  endgenerate
  assign snap[5] = fault_flags;
  assign snap[6] = actuator_status;
  assign snap[7] = snap[1] + snap[2] + snap[3] + snap[4] + snap[5] + snap[6];

  // ---------------------------------------------------------------------------
  // Triggers. In IDLE the fault bitmap is compared with the last one sent.
  // While a packet is in flight it is compared with the value being sent,
  // which becomes last_fault when the packet ends. So a fault change only
  // queues a follow-up packet if the bitmap really differs from the one on the
  // wire. In LOAD the live value is being captured now, so it cannot differ.
  // ---------------------------------------------------------------------------
  always_comb begin
    fault_trig = 1'b0;
    case (state_reg)
      IDLE:    fault_trig = (fault_flags != last_fault_reg);
      LOAD:    fault_trig = 1'b0;
      default: fault_trig = (fault_flags != pkt_reg[5]);
    endcase
  end

  assign trigger = send_req | expiry | fault_trig;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (pending_reg || trigger) state_next = LOAD;
      LOAD: state_next = SEND;
      SEND: if (tx_ready) state_next = GAP;
      GAP:  state_next = last_byte_reg ? IDLE : SEND;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. tx_data comes straight from the frozen image, so it cannot
  // change while a byte waits for tx_ready.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    busy        = 1'b1;
    packet_done = 1'b0;
    case (state_reg)
      IDLE: busy = 1'b0;
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = pkt_reg[idx_reg];
      end
      GAP:  packet_done = last_byte_reg;
      default: ;
    endcase
  end

  assign pkt_count = pkt_count_reg;

  // ---------------------------------------------------------------------------
  // Datapath: pending request, byte index, packet image, counters.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg    <= 1'b0;
      idx_reg        <= 3'd0;
      last_byte_reg  <= 1'b0;
      last_fault_reg <= 8'h00;
      pkt_count_reg  <= 8'h00;
      for (int i = 0; i < 8; i++) pkt_reg[i] <= 8'h00;
    end else begin
      // A trigger in the IDLE->LOAD cycle is used by the packet that starts now.
      if (state_reg == IDLE && state_next == LOAD)
        pending_reg <= 1'b0;
      else if (trigger)
        pending_reg <= 1'b1;

      case (state_reg)
        LOAD: begin
          for (int i = 0; i < 8; i++) pkt_reg[i] <= snap[i];
          idx_reg       <= 3'd0;
          last_byte_reg <= 1'b0;
        end
        SEND: begin
          if (tx_ready) begin
            if (idx_reg == 3'd7)
              last_byte_reg <= 1'b1;
            else
              idx_reg <= idx_reg + 3'd1;
          end
        end
        GAP: begin
          if (last_byte_reg) begin
            last_byte_reg  <= 1'b0;
            pkt_count_reg  <= pkt_count_reg + 8'd1;
            last_fault_reg <= pkt_reg[5];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_packet_framer.sv
module tb_sensor_packet_framer;

  logic       clk = 1'b0;
  logic       rst_n;
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;

  // Instance A: periodic packets disabled
  logic       send_req_a;
  logic [1:0] temp_a, hum_a, light_a, soil_a;
  logic [7:0] fault_a, act_a;
  logic [7:0] tx_data_a;
  logic       tx_valid_a, tx_ready_a, busy_a, done_a;
  logic [7:0] pkt_count_a;

  // Instance B: PERIOD_CYCLES = 100
  logic       send_req_b;
  logic [1:0] zero2 = 2'b00;
  logic [7:0] zero8 = 8'h00;
  logic       ready_b = 1'b1;
  logic [7:0] tx_data_b;
  logic       tx_valid_b, busy_b, done_b;
  logic [7:0] pkt_count_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sensor_packet_framer #(.HEADER(8'hAA), .PERIOD_CYCLES(0), .TIMER_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .send_req(send_req_a),
    .sensor_temp(temp_a), .sensor_humidity(hum_a), .sensor_light(light_a), .sensor_soil(soil_a),
    .fault_flags(fault_a), .actuator_status(act_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .busy(busy_a), .packet_done(done_a), .pkt_count(pkt_count_a)
  );

  sensor_packet_framer #(.HEADER(8'hAA), .PERIOD_CYCLES(100), .TIMER_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .send_req(send_req_b),
    .sensor_temp(zero2), .sensor_humidity(zero2), .sensor_light(zero2), .sensor_soil(zero2),
    .fault_flags(zero8), .actuator_status(zero8),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(ready_b),
    .busy(busy_b), .packet_done(done_b), .pkt_count(pkt_count_b)
  );

  // Byte capture, hold-stability watch and packet_done count for instance A.
  // All inputs change at posedge+1, so the negedge view equals the posedge view.
  logic [7:0] q_a [$];
  int         done_cnt_a = 0;
  int         hold_err   = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clk) begin
    if (tx_valid_a && tx_ready_a) q_a.push_back(tx_data_a);
    if (done_a) done_cnt_a++;
    if (prev_stall && tx_valid_a && tx_data_a != prev_data) hold_err++;
    prev_stall = tx_valid_a && !tx_ready_a;
    prev_data  = tx_data_a;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_b [0:7];

  // Model of the packet: header, zero-extended classes, bitmaps, 8-bit sum.
  task automatic set_exp(input logic [1:0] t, input logic [1:0] h, input logic [1:0] l,
                         input logic [1:0] s, input logic [7:0] f, input logic [7:0] a);
    exp_b[0] = 8'hAA;
    exp_b[1] = {6'b0, t};
    exp_b[2] = {6'b0, h};
    exp_b[3] = {6'b0, l};
    exp_b[4] = {6'b0, s};
    exp_b[5] = f;
    exp_b[6] = a;
    exp_b[7] = exp_b[1] + exp_b[2] + exp_b[3] + exp_b[4] + exp_b[5] + exp_b[6];
  endtask

  task automatic check_pkt(input string tag);
    int n;
    n = q_a.size();
    check_val({tag, "_len"}, n, 8);
    for (int i = 0; i < 8; i++)
      check_val($sformatf("%s_b%0d", tag, i), (i < n) ? {24'h0, q_a[i]} : 32'hDEAD, {24'h0, exp_b[i]});
    $display("packet %s: %0d bytes, chk 0x%0h, count %0d", tag, n, (n == 8) ? q_a[7] : 8'h00, pkt_count_a);
    q_a.delete();
  endtask

  // Wait for A to start a packet and then to return to IDLE (bounded).
  task automatic run_a();
    for (int i = 0; i < 10 && !busy_a; i++) tick();
    for (int i = 0; i < 300 && busy_a; i++) tick();
    check_val("run_a_idle", busy_a, 0);
  endtask

  task automatic pulse_a();
    send_req_a = 1'b1;
    tick();
    send_req_a = 1'b0;
  endtask

  // Wait for the next LOAD (rising busy) on instance B; returns the cycle stamp.
  task automatic wait_b_start(output int t);
    int k;
    k = 0;
    while (busy_b && k < 300) begin tick(); k++; end
    while (!busy_b && k < 300) begin tick(); k++; end
    check_val("b_start_seen", busy_b, 1);
    t = cyc;
  endtask

  int s1, s2, s3, s4;
  logic [7:0] c2;
  int dn;

  initial begin
    rst_n = 1'b0;
    send_req_a = 0; send_req_b = 0;
    temp_a = 0; hum_a = 0; light_a = 0; soil_a = 0; fault_a = 0; act_a = 0;
    tx_ready_a = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check_val("rst_tx_data", tx_data_a, 0);
    check_val("rst_tx_valid", tx_valid_a, 0);
    check_val("rst_busy", busy_a, 0);
    check_val("rst_done", done_a, 0);
    check_val("rst_count", pkt_count_a, 0);

    // Periodic instance: 100-cycle spacing; 3 requests mid-packet give one extra packet
    wait_b_start(s1);
    wait_b_start(s2);
    c2 = pkt_count_b;
    check_val("b_period", s2 - s1, 100);
    for (int i = 0; i < 3; i++) begin
      tick(); send_req_b = 1'b1; tick(); send_req_b = 1'b0;
    end
    wait_b_start(s3);
    check_val("b_extra_gap", s3 - s2, 18);
    wait_b_start(s4);
    check_val("b_period_after_extra", s4 - s2, 100);
    check_val("b_count_delta", 8'(pkt_count_b - c2), 2);

    // Basic packet with latency check
    temp_a = 2; hum_a = 1; light_a = 3; soil_a = 0; fault_a = 8'h00; act_a = 8'h5A;
    set_exp(2, 1, 3, 0, 8'h00, 8'h5A);
    check_val("exp_chk_hand", exp_b[7], 8'h60);
    q_a.delete();
    dn = done_cnt_a;
    pulse_a();
    check_val("lat_load_busy", busy_a, 1);
    check_val("lat_load_valid", tx_valid_a, 0);
    tick();
    check_val("lat_send_valid", tx_valid_a, 1);
    check_val("lat_send_data", tx_data_a, 8'hAA);
    run_a();
    check_pkt("basic");
    check_val("basic_done_once", done_cnt_a - dn, 1);
    check_val("basic_count", pkt_count_a, 1);

    // Back-pressure on byte 3
    dn = done_cnt_a;
    pulse_a();
    for (int i = 0; i < 100 && q_a.size() < 3; i++) tick();
    tx_ready_a = 1'b0;
    tick();
    repeat (20) tick();
    check_val("stall_valid", tx_valid_a, 1);
    check_val("stall_data", tx_data_a, 8'h03);
    check_val("stall_qlen", q_a.size(), 3);
    tx_ready_a = 1'b1;
    run_a();
    check_pkt("stall");
    check_val("stall_hold", hold_err, 0);
    check_val("stall_done_once", done_cnt_a - dn, 1);
    check_val("stall_count", pkt_count_a, 2);

    // Fault change while idle triggers exactly one packet
    fault_a = 8'h04;
    set_exp(2, 1, 3, 0, 8'h04, 8'h5A);
    run_a();
    check_pkt("fault");
    repeat (100) tick();
    check_val("fault_no_repeat_count", pkt_count_a, 3);
    check_val("fault_no_repeat_busy", busy_a, 0);
    check_val("fault_no_repeat_bytes", q_a.size(), 0);

    // All-max packet (triggered by the fault change to FF), then wrap of pkt_count
    temp_a = 3; hum_a = 3; light_a = 3; soil_a = 3; fault_a = 8'hFF; act_a = 8'hFF;
    set_exp(3, 3, 3, 3, 8'hFF, 8'hFF);
    run_a();
    check_val("max_chk_hand", (q_a.size() == 8) ? q_a[7] : 8'h00, 8'h0A);
    check_pkt("max");
    check_val("max_count", pkt_count_a, 4);
    for (int i = 0; i < 251; i++) begin
      pulse_a();
      run_a();
      q_a.delete();
    end
    check_val("count_255", pkt_count_a, 255);
    pulse_a();
    run_a();
    q_a.delete();
    check_val("count_wrap", pkt_count_a, 0);

    // Reset while byte 4 is on the bus
    pulse_a();
    for (int i = 0; i < 100 && q_a.size() < 4; i++) tick();
    tx_ready_a = 1'b0;
    tick();
    check_val("pre_rst_valid", tx_valid_a, 1);
    check_val("pre_rst_data", tx_data_a, exp_b[4]);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", tx_valid_a, 0);
    check_val("mid_rst_data", tx_data_a, 0);
    check_val("mid_rst_busy", busy_a, 0);
    check_val("mid_rst_count", pkt_count_a, 0);
    tick();
    fault_a = 8'h00;
    tx_ready_a = 1'b1;
    rst_n = 1'b1;
    tick();
    q_a.delete();
    set_exp(3, 3, 3, 3, 8'h00, 8'hFF);
    pulse_a();
    run_a();
    check_pkt("after_rst");
    check_val("after_rst_count", pkt_count_a, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
